engine_set_ops_merge_kernel: RTL and testbench
==============================================

# engine_set_ops_merge_kernel

Downstream consumer of the set-ops configuration stage. Each job pops one `SetOpsConfiguration` word from the configuration FIFO and latches its `set_mask` and `set_operation`. It then merges two ascending, duplicate-free key streams (A, B) into one result stream using intersection, union or difference. Results go to the engine's output path with a correctly placed `last` flag and a per-job result count.

## Interface
- `DATA_WIDTH`, 32, key width in bits.
- `ID_CU`, `ID_BUNDLE`, `ID_LANE`, `ID_ENGINE`, `ID_MODULE`, 0, placement identifiers; no functional effect.
- `ap_clk` in 1: single clock; all logic on rising edge.
- `areset` in 1: asynchronous, active-high reset; clears all state.
- `configure_memory_in` in `SetOpsConfiguration`: `valid` + `payload.param.{set_mask, set_operation}` from the configuration FIFO.
- `fifo_configure_memory_signals_in` out `FIFOStateSignalsInput`: only `rd_en` driven; other fields 0.
- `a_valid`, `a_last` in 1; `a_data` in DATA_WIDTH; `a_ready` out 1: stream A.
- `b_valid`, `b_last` in 1; `b_data` in DATA_WIDTH; `b_ready` out 1: stream B.
- `out_valid` out 1; `out_data` out DATA_WIDTH; `out_last` out 1; `out_ready` in 1: result stream.
- `busy_out` out 1: high from config request until job done.
- `done_out` out 1: one-cycle pulse at job end.
- `result_count` out 32: elements emitted by the last or current job.

## Operation
- `set_operation` encoding:
  - 0: INTERSECT.
  - 1: UNION.
  - 2: DIFF (A minus B).
  - 3: DISCARD (consume both streams, emit nothing).
- `set_mask[0]` enables A; `set_mask[1]` enables B. A disabled lane is marked exhausted at latch; its ready stays 0 for the whole job.
- FSM states: IDLE, REQ, WAIT, RUN, FLUSH, DONE.
  - IDLE → REQ: unconditional, the cycle after reset release or after DONE.
  - REQ: `rd_en`=1 for exactly one cycle → WAIT.
  - WAIT: hold until `configure_memory_in.valid`; latch the param, clear `result_count`, set exhausted flags from the mask → RUN. No timeout.
  - RUN → FLUSH: both lanes exhausted.
  - FLUSH: release the held element with `out_last`=1 (skip if none) → DONE once the output register has accepted it.
  - DONE: `done_out`=1 for one cycle → IDLE.
- Lane exhausted flag: set when a pop occurs with `last`=1. Pop = ready && valid in the same cycle.
- RUN decisions: one per cycle. A/B ready are combinational from the state, flags and a comparison of `a_data`/`b_data`; there are no head registers.
  - Comparing needs both heads valid.
  - If one lane is exhausted, only the other head is needed.
  - A non-exhausted lane that is not valid stalls the decision.
- INTERSECT:
  - equal → emit A, pop both.
  - A<B → pop A.
  - A>B → pop B.
  - one lane exhausted → pop the rest of the other without emitting.
- UNION:
  - equal → emit once, pop both.
  - otherwise emit the smaller head and pop it.
  - one lane exhausted → emit the rest of the other.
- DIFF:
  - equal → pop both, no emit.
  - A<B → emit A, pop A.
  - A>B → pop B.
  - B exhausted → emit the rest of A.
  - A exhausted → discard the rest of B.
- Hold buffer H (one entry) plus output register O, so `out_last` can be placed correctly.
  - An emit writes H. If H is already valid, the old H moves to O with `last`=0.
  - Stall (both readies 0): emit pending && H valid && O valid && !`out_ready`.
- `result_count` increments by 1 per emit; it wraps at 2^32.
- Empty result: nothing is emitted, `out_last` never asserts, `done_out` still pulses, `result_count`=0.

## Timing
- Reset values: all outputs 0, FSM=IDLE, H/O invalid, flags clear.
- Reset asserted mid-job: the job is abandoned; no `done_out`, no partial `last`.
- `rd_en` asserts 2 cycles after `areset` deasserts (IDLE, then REQ).
- `busy_out` = 1 in REQ, WAIT, RUN and FLUSH.
- Throughput: one pop decision per cycle when `out_ready` is held high.
- An element appears on `out_*` 1 cycle after the next emit, or 1 cycle after FLUSH entry for the final element.
- O handshake: O holds `out_data`/`out_last`/`out_valid` stable until `out_ready`. It accepts new data when !`out_valid` || `out_ready`.
- Simultaneous last on A and B in one pop: both flags set; RUN → FLUSH the next cycle.
- `done_out` fires the cycle after the final `out_valid`&&`out_ready` handshake, or the cycle after FLUSH when the result is empty.

## Test plan
- INTERSECT, mask=3, A={1,3,5,7}, B={3,4,7} → out 3,7; `last` on 7; `result_count`=2; one `done_out`.
- UNION, A={1,2}, B={2,9}, with `out_ready` toggling 1/0 each cycle → out 1,2,9 in order; `last` only on 9; data stable while stalled.
- DIFF, A={2,4,6}, B={4,8} → out 2,6; `last` on 6; B fully consumed (8 popped).
- INTERSECT, A={1}, B={2} → no `out_valid`; `done_out` pulse; count=0. Next job: exactly one new `rd_en` pulse.
- UNION, mask=1, A={5,6}, B driving valid → out 5,6; `b_ready` never asserts.
- Assert `areset` after the 2nd emit of a UNION job → all outputs 0 next cycle; after release, a fresh `rd_en` appears 2 cycles later.

Source files
------------

// File: rtl/engine_set_ops_merge_kernel.sv
// Set-operation merge kernel: pulls one configuration word per job, then merges two sorted
// key streams (intersect / union / diff / discard) into a result stream with a correct last flag.
`timescale 1ns/100ps
module engine_set_ops_merge_kernel #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_CU      = 0,
  parameter int ID_BUNDLE  = 0,
  parameter int ID_LANE    = 0,
  parameter int ID_ENGINE  = 0,
  parameter int ID_MODULE  = 0
) (
  input  logic                  ap_clk,
  input  logic                  areset,
  input  logic                  configure_memory_in_valid,
  input  logic [1:0]            configure_memory_in_set_mask,
  input  logic [1:0]            configure_memory_in_set_operation,
  output logic                  fifo_configure_memory_signals_in_rd_en,
  input  logic                  a_valid,
  input  logic                  a_last,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic                  b_last,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [31:0]           result_count
);

  localparam logic [1:0] OP_INTERSECT = 2'd0;
  localparam logic [1:0] OP_UNION     = 2'd1;
  localparam logic [1:0] OP_DIFF      = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                r_state, w_nextState;
  logic [1:0]            r_op;
  logic                  r_exA, r_exB;
  logic [31:0]           r_count;
  logic                  r_hValid;
  logic [DATA_WIDTH-1:0] r_hData;
  logic                  r_oValid, r_oLast;
  logic [DATA_WIDTH-1:0] r_oData;

  logic                  w_decide, w_popA, w_popB, w_emit, w_stall, w_emitFire;
  logic [DATA_WIDTH-1:0] w_emitData;
  logic                  w_oAccept, w_flushMove, w_loadO, w_latch, w_exANext, w_exBNext;

  // Placement identifiers carry no logic; referencing them keeps them visible to elaboration.
  if (ID_CU < 0 || ID_BUNDLE < 0 || ID_LANE < 0 || ID_ENGINE < 0 || ID_MODULE < 0) begin : g_badPlacementId
  end

  always_comb begin
    w_popA     = 1'b0;
    w_popB     = 1'b0;
    w_emit     = 1'b0;
    w_emitData = a_data;
    w_decide   = (r_state == S_RUN) && !(r_exA && r_exB) &&
                 (r_exA || a_valid) && (r_exB || b_valid);
    if (w_decide) begin
      if (!r_exA && !r_exB) begin
        case (r_op)
          OP_INTERSECT: begin
            w_popA = (a_data <= b_data);
            w_popB = (a_data >= b_data);
            w_emit = (a_data == b_data);
          end
          OP_UNION: begin
            w_popA = (a_data <= b_data);
            w_popB = (a_data >= b_data);
            w_emit = 1'b1;
            if (a_data > b_data) w_emitData = b_data;
          end
          OP_DIFF: begin
            w_popA = (a_data <= b_data);
            w_popB = (a_data >= b_data);
            w_emit = (a_data < b_data);
          end
          default: begin
            w_popA = 1'b1;
            w_popB = 1'b1;
          end
        endcase
      end else if (r_exB) begin
        w_popA = 1'b1;
        w_emit = (r_op == OP_UNION) || (r_op == OP_DIFF);
      end else begin
        w_popB     = 1'b1;
        w_emit     = (r_op == OP_UNION);
        w_emitData = b_data;
      end
    end
  end

  // An emit with H full needs O free; otherwise the whole decision waits.
  assign w_stall     = w_emit && r_hValid && r_oValid && !out_ready;
  assign w_emitFire  = w_emit && !w_stall;
  assign a_ready     = w_popA && !w_stall;
  assign b_ready     = w_popB && !w_stall;
  assign w_oAccept   = !r_oValid || out_ready;
  assign w_flushMove = (r_state == S_FLUSH) && r_hValid && w_oAccept;
  assign w_loadO     = (w_emitFire && r_hValid) || w_flushMove;
  assign w_latch     = (r_state == S_WAIT) && configure_memory_in_valid;
  assign w_exANext   = r_exA || (a_ready && a_valid && a_last);
  assign w_exBNext   = r_exB || (b_ready && b_valid && b_last);

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  w_nextState = S_REQ;
      S_REQ:   w_nextState = S_WAIT;
      S_WAIT:  if (configure_memory_in_valid) w_nextState = S_RUN;
      S_RUN:   if (w_exANext && w_exBNext) w_nextState = S_FLUSH;
      S_FLUSH: if (!r_hValid && w_oAccept) w_nextState = S_DONE;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      r_op    <= 2'd0;
      r_exA   <= 1'b0;
      r_exB   <= 1'b0;
      r_count <= 32'd0;
    end else if (w_latch) begin
      r_op    <= configure_memory_in_set_operation;
      r_exA   <= !configure_memory_in_set_mask[0];
      r_exB   <= !configure_memory_in_set_mask[1];
      r_count <= 32'd0;
    end else begin
      r_exA <= w_exANext;
      r_exB <= w_exBNext;
      if (w_emitFire) r_count <= r_count + 32'd1;
    end
  end

  // H always keeps the newest emit back so the final element can be tagged last at flush.
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      r_hValid <= 1'b0;
      r_hData  <= '0;
      r_oValid <= 1'b0;
      r_oLast  <= 1'b0;
      r_oData  <= '0;
    end else begin
      if (w_loadO) begin
        r_oValid <= 1'b1;
        r_oData  <= r_hData;
        r_oLast  <= w_flushMove;
      end else if (r_oValid && out_ready) begin
        r_oValid <= 1'b0;
        r_oLast  <= 1'b0;
      end
      if (w_emitFire) begin
        r_hValid <= 1'b1;
        r_hData  <= w_emitData;
      end else if (w_flushMove) begin
        r_hValid <= 1'b0;
      end
    end
  end

  assign fifo_configure_memory_signals_in_rd_en = (r_state == S_REQ);
  assign busy_out     = (r_state == S_REQ) || (r_state == S_WAIT) ||
                        (r_state == S_RUN) || (r_state == S_FLUSH);
  assign done_out     = (r_state == S_DONE);
  assign out_valid    = r_oValid;
  assign out_data     = r_oData;
  assign out_last     = r_oLast;
  assign result_count = r_count;

endmodule

// File: tb/tb_engine_set_ops_merge_kernel.sv
// Directed bench for the set-ops merge kernel: drives sorted key streams and a config FIFO model,
// records output handshakes, and compares against hand-computed results per scenario.
`timescale 1ns/100ps
module tb_engine_set_ops_merge_kernel;

  logic        ap_clk = 1'b0;
  logic        areset = 1'b1;
  logic        cfgValid = 1'b0;
  logic [1:0]  cfgMask = 2'd0, cfgOp = 2'd0;
  logic        rdEn;
  logic        a_valid = 1'b0, a_last = 1'b0, a_ready;
  logic [31:0] a_data = '0;
  logic        b_valid = 1'b0, b_last = 1'b0, b_ready;
  logic [31:0] b_data = '0;
  logic        out_valid, out_last, busy_out, done_out;
  logic        out_ready = 1'b1;
  logic [31:0] out_data, result_count;

  int passCount = 0, checkCount = 0;

  // Stream sources and config FIFO model
  logic [31:0] aMem [4];
  logic [31:0] bMem [4];
  int aLen = 0, bLen = 0, aIdx = 0, bIdx = 0;
  bit srcOn = 0, readyMode = 0, cfgAvail = 0, rdPending = 0;
  logic [1:0] jobMask = 2'd3, jobOp = 2'd0;

  // Observations
  logic [31:0] outQ [$];
  bit          lastQ [$];
  int doneCount = 0, rdCount = 0, aPops = 0, bPops = 0, stableErr = 0, lastCount = 0, tick = 0;
  bit validSeen = 0, bReadySeen = 0, prevValid = 0, prevReady = 0, prevLast = 0;
  logic [31:0] prevData = '0;

  always #5 ap_clk = ~ap_clk;

  engine_set_ops_merge_kernel #(.DATA_WIDTH(32)) dut (
    .ap_clk(ap_clk),
    .areset(areset),
    .configure_memory_in_valid(cfgValid),
    .configure_memory_in_set_mask(cfgMask),
    .configure_memory_in_set_operation(cfgOp),
    .fifo_configure_memory_signals_in_rd_en(rdEn),
    .a_valid(a_valid), .a_last(a_last), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_last(b_last), .b_data(b_data), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy_out(busy_out),
    .done_out(done_out),
    .result_count(result_count)
  );

  // Drive on the falling edge, sample handshakes 2 time units before the rising edge.
  always @(negedge ap_clk) begin
    a_valid = srcOn && (aIdx < aLen);
    if (aIdx < aLen) a_data = aMem[aIdx]; else a_data = '0;
    a_last  = (aIdx == aLen - 1);
    b_valid = srcOn && (bIdx < bLen);
    if (bIdx < bLen) b_data = bMem[bIdx]; else b_data = '0;
    b_last  = (bIdx == bLen - 1);
    cfgValid  = rdPending && cfgAvail;
    cfgMask   = jobMask;
    cfgOp     = jobOp;
    out_ready = readyMode ? tick[0] : 1'b1;
    #3;
    tick++;
    if (a_valid && a_ready) begin aIdx++; aPops++; end
    if (b_valid && b_ready) begin bIdx++; bPops++; end
    if (out_valid && out_ready) begin
      outQ.push_back(out_data);
      lastQ.push_back(out_last);
      if (out_last) lastCount++;
    end
    if (out_valid) validSeen = 1;
    if (b_ready) bReadySeen = 1;
    if (done_out) doneCount++;
    if (cfgValid) begin rdPending = 0; cfgAvail = 0; end
    if (rdEn) begin rdCount++; rdPending = 1; end
    if (prevValid && !prevReady && (!out_valid || out_data != prevData || out_last != prevLast))
      stableErr++;
    prevValid = out_valid;
    prevReady = out_ready;
    prevData  = out_data;
    prevLast  = out_last;
  end

  task automatic loadStreams(input int na, input logic [31:0] a0, a1, a2, a3,
                             input int nb, input logic [31:0] b0, b1, b2);
    aMem[0] = a0; aMem[1] = a1; aMem[2] = a2; aMem[3] = a3; aLen = na;
    bMem[0] = b0; bMem[1] = b1; bMem[2] = b2; bMem[3] = '0; bLen = nb;
  endtask

  task automatic startJob(input logic [1:0] op, input logic [1:0] mask, input bit rm);
    outQ.delete();
    lastQ.delete();
    aIdx = 0; bIdx = 0; aPops = 0; bPops = 0;
    doneCount = 0; rdCount = 0; stableErr = 0; lastCount = 0;
    validSeen = 0; bReadySeen = 0;
    readyMode = rm; jobOp = op; jobMask = mask;
    srcOn = 1; cfgAvail = 1;
  endtask

  task automatic waitDone(output bit ok);
    int i;
    i = 0;
    while (doneCount == 0 && i < 300) begin
      @(negedge ap_clk); #4;
      i++;
    end
    ok = (doneCount != 0);
    repeat (3) begin @(negedge ap_clk); #4; end
  endtask

  task automatic test_reset();
    int n;
    areset = 1;
    repeat (3) @(negedge ap_clk);
    #4;
    checkCount++;
    if ({rdEn, busy_out, done_out, out_valid, out_last, a_ready, b_ready} !== 7'b0)
      $display("[TB] FAIL reset_ctrl: got %b expected 0000000",
               {rdEn, busy_out, done_out, out_valid, out_last, a_ready, b_ready});
    else passCount++;
    checkCount++;
    if (out_data !== 32'd0 || result_count !== 32'd0)
      $display("[TB] FAIL reset_data: got data=%0d count=%0d expected 0/0", out_data, result_count);
    else passCount++;
    @(negedge ap_clk);
    areset = 0;
    #4;
    n = 1;
    while (!rdEn && n < 10) begin @(negedge ap_clk); #4; n++; end
    checkCount++;
    if (n !== 2) $display("[TB] FAIL reset_rd_latency: got %0d expected 2", n);
    else passCount++;
  endtask

  task automatic test_intersect();
    bit ok;
    loadStreams(4, 1, 3, 5, 7, 3, 3, 4, 7);
    startJob(2'd0, 2'd3, 0);
    waitDone(ok);
    checkCount++;
    if (!ok) $display("[TB] FAIL intersect_timeout: got 0 expected 1"); else passCount++;
    checkCount++;
    if (outQ.size() !== 2) $display("[TB] FAIL intersect_len: got %0d expected 2", outQ.size());
    else passCount++;
    checkCount++;
    if (outQ[0] !== 32'd3 || outQ[1] !== 32'd7)
      $display("[TB] FAIL intersect_data: got %0d,%0d expected 3,7", outQ[0], outQ[1]);
    else passCount++;
    checkCount++;
    if (lastQ[0] !== 1'b0 || lastQ[1] !== 1'b1 || lastCount !== 1)
      $display("[TB] FAIL intersect_last: got %b%b n=%0d expected 01 n=1", lastQ[0], lastQ[1], lastCount);
    else passCount++;
    checkCount++;
    if (result_count !== 32'd2) $display("[TB] FAIL intersect_count: got %0d expected 2", result_count);
    else passCount++;
    checkCount++;
    if (doneCount !== 1) $display("[TB] FAIL intersect_done: got %0d expected 1", doneCount);
    else passCount++;
  endtask

  task automatic test_union_backpressure();
    bit ok;
    loadStreams(2, 1, 2, 0, 0, 2, 2, 9, 0);
    startJob(2'd1, 2'd3, 1);
    waitDone(ok);
    readyMode = 0;
    checkCount++;
    if (!ok) $display("[TB] FAIL union_timeout: got 0 expected 1"); else passCount++;
    checkCount++;
    if (outQ.size() !== 3) $display("[TB] FAIL union_len: got %0d expected 3", outQ.size());
    else passCount++;
    checkCount++;
    if (outQ[0] !== 32'd1 || outQ[1] !== 32'd2 || outQ[2] !== 32'd9)
      $display("[TB] FAIL union_data: got %0d,%0d,%0d expected 1,2,9", outQ[0], outQ[1], outQ[2]);
    else passCount++;
    checkCount++;
    if (lastQ[2] !== 1'b1 || lastCount !== 1)
      $display("[TB] FAIL union_last: got %b n=%0d expected 1 n=1", lastQ[2], lastCount);
    else passCount++;
    checkCount++;
    if (stableErr !== 0) $display("[TB] FAIL union_stable: got %0d expected 0", stableErr);
    else passCount++;
    checkCount++;
    if (result_count !== 32'd3) $display("[TB] FAIL union_count: got %0d expected 3", result_count);
    else passCount++;
  endtask

  task automatic test_diff();
    bit ok;
    loadStreams(3, 2, 4, 6, 0, 2, 4, 8, 0);
    startJob(2'd2, 2'd3, 0);
    waitDone(ok);
    checkCount++;
    if (!ok) $display("[TB] FAIL diff_timeout: got 0 expected 1"); else passCount++;
    checkCount++;
    if (outQ.size() !== 2 || outQ[0] !== 32'd2 || outQ[1] !== 32'd6)
      $display("[TB] FAIL diff_data: got n=%0d %0d,%0d expected n=2 2,6", outQ.size(), outQ[0], outQ[1]);
    else passCount++;
    checkCount++;
    if (lastQ[1] !== 1'b1 || lastCount !== 1)
      $display("[TB] FAIL diff_last: got %b n=%0d expected 1 n=1", lastQ[1], lastCount);
    else passCount++;
    checkCount++;
    if (bPops !== 2 || aPops !== 3)
      $display("[TB] FAIL diff_pops: got a=%0d b=%0d expected a=3 b=2", aPops, bPops);
    else passCount++;
  endtask

  task automatic test_empty_intersect();
    bit ok;
    loadStreams(1, 1, 0, 0, 0, 1, 2, 0, 0);
    startJob(2'd0, 2'd3, 0);
    waitDone(ok);
    repeat (10) begin @(negedge ap_clk); #4; end
    checkCount++;
    if (!ok) $display("[TB] FAIL empty_timeout: got 0 expected 1"); else passCount++;
    checkCount++;
    if (validSeen !== 1'b0) $display("[TB] FAIL empty_valid: got %0b expected 0", validSeen);
    else passCount++;
    checkCount++;
    if (doneCount !== 1) $display("[TB] FAIL empty_done: got %0d expected 1", doneCount);
    else passCount++;
    checkCount++;
    if (result_count !== 32'd0) $display("[TB] FAIL empty_count: got %0d expected 0", result_count);
    else passCount++;
    checkCount++;
    if (rdCount !== 1) $display("[TB] FAIL empty_next_rd: got %0d expected 1", rdCount);
    else passCount++;
  endtask

  task automatic test_masked_union();
    bit ok;
    loadStreams(2, 5, 6, 0, 0, 1, 7, 0, 0);
    startJob(2'd1, 2'd1, 0);
    waitDone(ok);
    checkCount++;
    if (!ok) $display("[TB] FAIL masked_timeout: got 0 expected 1"); else passCount++;
    checkCount++;
    if (outQ.size() !== 2 || outQ[0] !== 32'd5 || outQ[1] !== 32'd6)
      $display("[TB] FAIL masked_data: got n=%0d %0d,%0d expected n=2 5,6", outQ.size(), outQ[0], outQ[1]);
    else passCount++;
    checkCount++;
    if (lastQ[1] !== 1'b1 || lastCount !== 1)
      $display("[TB] FAIL masked_last: got %b n=%0d expected 1 n=1", lastQ[1], lastCount);
    else passCount++;
    checkCount++;
    if (bReadySeen !== 1'b0) $display("[TB] FAIL masked_b_ready: got %0b expected 0", bReadySeen);
    else passCount++;
  endtask

  task automatic test_reset_mid_job();
    int i, n;
    loadStreams(4, 1, 3, 5, 7, 2, 2, 4, 0);
    startJob(2'd1, 2'd3, 0);
    i = 0;
    while (result_count != 32'd2 && i < 100) begin @(negedge ap_clk); #4; i++; end
    checkCount++;
    if (result_count !== 32'd2) $display("[TB] FAIL midreset_reach: got %0d expected 2", result_count);
    else passCount++;
    areset = 1;
    srcOn = 0;
    cfgAvail = 0;
    @(negedge ap_clk); #4;
    checkCount++;
    if ({rdEn, busy_out, done_out, out_valid, out_last, a_ready, b_ready} !== 7'b0)
      $display("[TB] FAIL midreset_ctrl: got %b expected 0000000",
               {rdEn, busy_out, done_out, out_valid, out_last, a_ready, b_ready});
    else passCount++;
    checkCount++;
    if (out_data !== 32'd0 || result_count !== 32'd0)
      $display("[TB] FAIL midreset_data: got data=%0d count=%0d expected 0/0", out_data, result_count);
    else passCount++;
    checkCount++;
    if (doneCount !== 0 || lastCount !== 0)
      $display("[TB] FAIL midreset_abandon: got done=%0d last=%0d expected 0/0", doneCount, lastCount);
    else passCount++;
    @(negedge ap_clk);
    areset = 0;
    #4;
    n = 1;
    while (!rdEn && n < 10) begin @(negedge ap_clk); #4; n++; end
    checkCount++;
    if (n !== 2) $display("[TB] FAIL midreset_rd_latency: got %0d expected 2", n);
    else passCount++;
  endtask

  initial begin
    test_reset();
    test_intersect();
    test_union_backpressure();
    test_diff();
    test_empty_intersect();
    test_masked_union();
    test_reset_mid_job();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
